// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter slice: bus command/size encodings,
// the FU memory packet, arbiter state and request-source enums.
package sys_defs;

   localparam int XLEN                  = 64;
   localparam int MEM_LATENCY_IN_CYCLES = 2;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;

   typedef enum logic [1:0] {
      BYTE   = 2'h0,
      HALF   = 2'h1,
      WORD   = 2'h2,
      DOUBLE = 2'h3
   } MEM_SIZE;

   typedef struct packed {
      BUS_COMMAND      cmd;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] data;
      MEM_SIZE         size;
   } FU_MEM_PACKET;

   typedef enum logic [1:0] {
      IDLE  = 2'h0,
      ISSUE = 2'h1,
      BUSY  = 2'h2
   } ARB_STATE;

   typedef enum logic [1:0] {
      SRC_NONE  = 2'h0,
      SRC_STORE = 2'h1,
      SRC_LOAD  = 2'h2,
      SRC_FETCH = 2'h3
   } ARB_SRC;

   // Counter width able to hold 0..lat-1, never narrower than one bit.
   function automatic int cnt_width(input int lat);
      return (lat < 1) ? 1 : $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/dmem_arbiter_arb_pick.sv
// Combinational winner select: store > load > fetch, unless fetch has been
// starved long enough, in which case a pending fetch takes the bus.
module arb_pick
   import sys_defs::*;
(
   input  logic            store_req,
   input  logic            load_req,
   input  logic            fetch_req,
   input  logic            starved,
   input  FU_MEM_PACKET    store_pkt,
   input  FU_MEM_PACKET    load_pkt,
   input  logic [XLEN-1:0] fetch_addr,
   output ARB_SRC          src,
   output FU_MEM_PACKET    pkt
);

   // Priority select, then build the packet for the chosen source.
   always_comb begin
      src = SRC_NONE;
      pkt = '0;
      if (fetch_req && starved) begin
         src = SRC_FETCH;
      end else if (store_req) begin
         src = SRC_STORE;
      end else if (load_req) begin
         src = SRC_LOAD;
      end else if (fetch_req) begin
         src = SRC_FETCH;
      end
      case (src)
         SRC_STORE: pkt = store_pkt;
         SRC_LOAD:  pkt = load_pkt;
         SRC_FETCH: begin
            // instruction fetch is always a full-width read
            pkt.cmd  = BUS_LOAD;
            pkt.addr = fetch_addr;
            pkt.data = '0;
            pkt.size = DOUBLE;
         end
         default:   pkt = '0;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port memory arbiter: merges store, load and fetch requests onto the
// proc2mem bus, acks the winner for one cycle and then holds the bus for the
// fixed memory latency. Read data is passed straight through.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | bus free; arbitrate any pending request and latch the winner
//  ISSUE | one cycle: latched packet on proc2mem_*, winner's ack high
//  BUSY  | memory latency window; bus idle, new requests not accepted
module dmem_arbiter
   import sys_defs::*;
#(
   parameter int LAT          = MEM_LATENCY_IN_CYCLES,
   parameter int STARVE_LIMIT = 4
)
(
   input  logic            clock,
   input  logic            reset,
   input  logic            load_req,
   input  FU_MEM_PACKET    load_pkt,
   input  logic            store_req,
   input  FU_MEM_PACKET    store_pkt,
   input  logic            fetch_req,
   input  logic [XLEN-1:0] fetch_addr,
   input  logic [XLEN-1:0] mem2proc_data,
   output logic            load_ack,
   output logic            store_ack,
   output logic            fetch_ack,
   output BUS_COMMAND      proc2mem_command,
   output logic [XLEN-1:0] proc2mem_addr,
   output logic [XLEN-1:0] proc2mem_data,
   output MEM_SIZE         proc2mem_size,
   output logic [XLEN-1:0] Dmem2proc_data,
   output logic            busy
);

   localparam int CNT_W = cnt_width(LAT);
   localparam int STV_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LAT > 0) ? LAT - 1 : 0);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

   ARB_STATE         state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [STV_W-1:0] starve_q, starve_d;
   FU_MEM_PACKET     pkt_q, pkt_d;
   ARB_SRC           src_q, src_d;

   ARB_SRC           pick_src;
   FU_MEM_PACKET     pick_pkt;
   logic             starved;
   logic             issuing;

   assign starved = (starve_q == STV_MAX);
   assign issuing = (state_q == ISSUE);

   arb_pick u_pick (
      .store_req  (store_req),
      .load_req   (load_req),
      .fetch_req  (fetch_req),
      .starved    (starved),
      .store_pkt  (store_pkt),
      .load_pkt   (load_pkt),
      .fetch_addr (fetch_addr),
      .src        (pick_src),
      .pkt        (pick_pkt)
   );

   // State, latency counter, starvation counter and latched winner.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         starve_q <= '0;
         pkt_q    <= '0;
         src_q    <= SRC_NONE;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         pkt_q    <= pkt_d;
         src_q    <= src_d;
      end
   end

   // Next-state: grant in IDLE, one ISSUE cycle, then LAT cycles of BUSY.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pkt_d   = pkt_q;
      src_d   = src_q;
      case (state_q)
         IDLE: begin
            if (pick_src != SRC_NONE) begin
               state_d = ISSUE;
               pkt_d   = pick_pkt;
               src_d   = pick_src;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = (LAT > 0) ? BUSY : IDLE;
         end
         BUSY: begin
            if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Fetch starvation: count IDLE arbitrations a pending fetch loses.
   always_comb begin
      starve_d = starve_q;
      if (!fetch_req) begin
         starve_d = '0;
      end else if (state_q == IDLE) begin
         if (pick_src == SRC_FETCH) begin
            starve_d = '0;
         end else if (starve_q != STV_MAX) begin
            starve_d = starve_q + STV_W'(1);
         end
      end
   end

   // Bus and ack outputs decode from the registered state and latched packet.
   always_comb begin
      load_ack         = issuing && (src_q == SRC_LOAD);
      store_ack        = issuing && (src_q == SRC_STORE);
      fetch_ack        = issuing && (src_q == SRC_FETCH);
      proc2mem_command = BUS_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      proc2mem_size    = BYTE;
      if (issuing) begin
         proc2mem_command = pkt_q.cmd;
         proc2mem_addr    = pkt_q.addr;
         proc2mem_data    = pkt_q.data;
         proc2mem_size    = pkt_q.size;
      end
   end

   assign Dmem2proc_data = mem2proc_data;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (LAT=2 and LAT=0) driven by requesters
// that hold req until ack, compared every cycle against a bus-occupancy model.
module tb_dmem_arbiter;
   import sys_defs::*;

   localparam int NI     = 2;
   localparam int STARVE = 4;
   localparam int W_NONE = 0, W_STORE = 1, W_LOAD = 2, W_FETCH = 3;

   logic            clock = 1'b0;
   logic            reset;
   logic            load_req [NI];
   logic            store_req[NI];
   logic            fetch_req[NI];
   FU_MEM_PACKET    load_pkt [NI];
   FU_MEM_PACKET    store_pkt[NI];
   logic [XLEN-1:0] fetch_addr[NI];
   logic [XLEN-1:0] mem2proc_data;
   logic            load_ack [NI];
   logic            store_ack[NI];
   logic            fetch_ack[NI];
   BUS_COMMAND      p_cmd [NI];
   logic [XLEN-1:0] p_addr[NI];
   logic [XLEN-1:0] p_data[NI];
   MEM_SIZE         p_size[NI];
   logic [XLEN-1:0] dmem_data[NI];
   logic            busy[NI];

   int n_checks = 0;
   int n_fail   = 0;

   // model: cycles the bus stays occupied after the current one, fetch losses
   int              m_left  [NI];
   int              m_starve[NI];
   int              e_win   [NI];
   BUS_COMMAND      e_cmd   [NI];
   logic [XLEN-1:0] e_addr  [NI];
   logic [XLEN-1:0] e_data  [NI];
   MEM_SIZE         e_size  [NI];
   int              glog[$];

   always #5 clock = ~clock;

   dmem_arbiter #(.LAT(2), .STARVE_LIMIT(STARVE)) dut_lat2 (
      .clock(clock), .reset(reset),
      .load_req(load_req[0]), .load_pkt(load_pkt[0]),
      .store_req(store_req[0]), .store_pkt(store_pkt[0]),
      .fetch_req(fetch_req[0]), .fetch_addr(fetch_addr[0]),
      .mem2proc_data(mem2proc_data),
      .load_ack(load_ack[0]), .store_ack(store_ack[0]), .fetch_ack(fetch_ack[0]),
      .proc2mem_command(p_cmd[0]), .proc2mem_addr(p_addr[0]),
      .proc2mem_data(p_data[0]), .proc2mem_size(p_size[0]),
      .Dmem2proc_data(dmem_data[0]), .busy(busy[0])
   );

   dmem_arbiter #(.LAT(0), .STARVE_LIMIT(STARVE)) dut_lat0 (
      .clock(clock), .reset(reset),
      .load_req(load_req[1]), .load_pkt(load_pkt[1]),
      .store_req(store_req[1]), .store_pkt(store_pkt[1]),
      .fetch_req(fetch_req[1]), .fetch_addr(fetch_addr[1]),
      .mem2proc_data(mem2proc_data),
      .load_ack(load_ack[1]), .store_ack(store_ack[1]), .fetch_ack(fetch_ack[1]),
      .proc2mem_command(p_cmd[1]), .proc2mem_addr(p_addr[1]),
      .proc2mem_data(p_data[1]), .proc2mem_size(p_size[1]),
      .Dmem2proc_data(dmem_data[1]), .busy(busy[1])
   );

   function automatic int lat_of(input int i);
      return (i == 0) ? 2 : 0;
   endfunction

   function automatic FU_MEM_PACKET rand_pkt(input BUS_COMMAND c);
      FU_MEM_PACKET p;
      p.cmd  = c;
      p.addr = {$urandom, $urandom};
      p.data = {$urandom, $urandom};
      p.size = MEM_SIZE'($urandom_range(0, 3));
      return p;
   endfunction

   task automatic chk(input int inst, input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, inst, $time, act, exp);
      end
   endtask

   // One clock: predict from current inputs, clock, run requesters, compare.
   task automatic step(input bit rnd);
      int  w;
      bit  acked_s, acked_l, acked_f;
      for (int i = 0; i < NI; i++) begin
         e_win[i] = W_NONE;
         if (reset) begin
            m_left[i]   = 0;
            m_starve[i] = 0;
         end else begin
            if (!fetch_req[i]) m_starve[i] = 0;
            if (m_left[i] > 0) begin
               m_left[i]--;
            end else if (store_req[i] || load_req[i] || fetch_req[i]) begin
               if (fetch_req[i] && m_starve[i] == STARVE) w = W_FETCH;
               else if (store_req[i])                     w = W_STORE;
               else if (load_req[i])                      w = W_LOAD;
               else                                       w = W_FETCH;
               if (fetch_req[i])
                  m_starve[i] = (w == W_FETCH) ? 0 :
                                ((m_starve[i] < STARVE) ? m_starve[i] + 1 : STARVE);
               e_win[i]  = w;
               m_left[i] = 1 + lat_of(i);
               case (w)
                  W_STORE: begin
                     e_cmd[i] = BUS_STORE; e_addr[i] = store_pkt[i].addr;
                     e_data[i] = store_pkt[i].data; e_size[i] = store_pkt[i].size;
                  end
                  W_LOAD: begin
                     e_cmd[i] = BUS_LOAD; e_addr[i] = load_pkt[i].addr;
                     e_data[i] = '0; e_size[i] = load_pkt[i].size;
                  end
                  default: begin
                     e_cmd[i] = BUS_LOAD; e_addr[i] = fetch_addr[i];
                     e_data[i] = '0; e_size[i] = DOUBLE;
                  end
               endcase
            end
         end
      end

      @(posedge clock);
      #1;
      if (store_ack[0]) glog.push_back(W_STORE);
      if (load_ack[0])  glog.push_back(W_LOAD);
      if (fetch_ack[0]) glog.push_back(W_FETCH);
      for (int i = 0; i < NI; i++) begin
         acked_s = store_ack[i];
         acked_l = load_ack[i];
         acked_f = fetch_ack[i];
         if (acked_s) store_req[i] = 1'b0;
         if (acked_l) load_req[i]  = 1'b0;
         if (acked_f) fetch_req[i] = 1'b0;
         // idle requesters scramble their packets; the latched copy must hold
         if (!store_req[i]) store_pkt[i]  = rand_pkt(BUS_STORE);
         if (!load_req[i])  load_pkt[i]   = rand_pkt(BUS_LOAD);
         if (!fetch_req[i]) fetch_addr[i] = {$urandom, $urandom};
         if (rnd) begin
            if (!store_req[i] && !acked_s) store_req[i] = ($urandom_range(0, 3) == 0);
            if (!load_req[i]  && !acked_l) load_req[i]  = ($urandom_range(0, 3) == 0);
            if (!fetch_req[i] && !acked_f) fetch_req[i] = ($urandom_range(0, 3) == 0);
         end
      end
      if (rnd) reset = ($urandom_range(0, 49) == 0);
      mem2proc_data = {$urandom, $urandom};
      #1;

      for (int i = 0; i < NI; i++) begin
         chk(i, "store_ack", store_ack[i], e_win[i] == W_STORE);
         chk(i, "load_ack",  load_ack[i],  e_win[i] == W_LOAD);
         chk(i, "fetch_ack", fetch_ack[i], e_win[i] == W_FETCH);
         chk(i, "cmd",  p_cmd[i],  (e_win[i] != W_NONE) ? e_cmd[i]  : BUS_NONE);
         chk(i, "addr", p_addr[i], (e_win[i] != W_NONE) ? e_addr[i] : '0);
         chk(i, "size", p_size[i], (e_win[i] != W_NONE) ? e_size[i] : BYTE);
         if (e_win[i] == W_STORE || e_win[i] == W_NONE)
            chk(i, "data", p_data[i], (e_win[i] == W_STORE) ? e_data[i] : '0);
         chk(i, "busy", busy[i], m_left[i] > 0);
         chk(i, "dmem_data", dmem_data[i], mem2proc_data);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0);
   endtask

   initial begin
      int          gap;
      bit          seen;
      int          seq;
      logic [9:0]  pat;

      reset = 1'b1;
      mem2proc_data = '0;
      for (int i = 0; i < NI; i++) begin
         load_req[i] = 1'b0; store_req[i] = 1'b0; fetch_req[i] = 1'b0;
         load_pkt[i] = '0;   store_pkt[i] = '0;   fetch_addr[i] = '0;
         m_left[i] = 0; m_starve[i] = 0; e_win[i] = W_NONE;
         e_cmd[i] = BUS_NONE; e_addr[i] = '0; e_data[i] = '0; e_size[i] = BYTE;
      end
      idle(2);
      chk(0, "reset_busy", busy[0], 1'b0);
      chk(0, "reset_cmd", p_cmd[0], BUS_NONE);
      reset = 1'b0;
      idle(1);

      // single load, LAT=2
      load_pkt[0].cmd = BUS_LOAD; load_pkt[0].addr = 64'h100;
      load_pkt[0].data = '0;      load_pkt[0].size = BYTE;
      load_req[0] = 1'b1;
      step(1'b0);
      chk(0, "t1_ack", load_ack[0], 1'b1);
      chk(0, "t1_cmd", p_cmd[0], BUS_LOAD);
      chk(0, "t1_addr", p_addr[0], 64'h100);
      chk(0, "t1_size", p_size[0], BYTE);
      step(1'b0);
      chk(0, "t1_busy1_cmd", p_cmd[0], BUS_NONE);
      chk(0, "t1_busy1", busy[0], 1'b1);
      step(1'b0);
      chk(0, "t1_busy2", busy[0], 1'b1);
      step(1'b0);
      chk(0, "t1_idle", busy[0], 1'b0);

      // read data pass-through, no extension
      mem2proc_data = 64'h80;
      #1;
      chk(0, "t6_passthru", dmem_data[0], 64'h80);

      // store beats load; load follows 2+LAT cycles later
      store_pkt[0].cmd = BUS_STORE; store_pkt[0].addr = 64'h200;
      store_pkt[0].data = 64'hDEADBEEF; store_pkt[0].size = WORD;
      load_pkt[0].cmd = BUS_LOAD; load_pkt[0].addr = 64'h300;
      load_pkt[0].data = '0; load_pkt[0].size = DOUBLE;
      store_req[0] = 1'b1; load_req[0] = 1'b1;
      step(1'b0);
      chk(0, "t2_store_ack", store_ack[0], 1'b1);
      chk(0, "t2_load_ack", load_ack[0], 1'b0);
      chk(0, "t2_cmd", p_cmd[0], BUS_STORE);
      chk(0, "t2_data", p_data[0], 64'hDEADBEEF);
      gap = 0; seen = 1'b0;
      for (int s = 1; s <= 10 && !seen; s++) begin
         step(1'b0);
         if (load_ack[0]) begin seen = 1'b1; gap = s; end
      end
      chk(0, "t2_load_gap", gap, 4);
      chk(0, "t2_load_addr", p_addr[0], 64'h300);
      idle(4);

      // fetch starvation with store/load alternating
      glog.delete();
      store_req[0] = 1'b1; fetch_req[0] = 1'b1;
      for (int s = 0; s < 40 && glog.size() < 5; s++) begin
         step(1'b0);
         if (store_ack[0]) load_req[0]  = 1'b1;
         if (load_ack[0])  store_req[0] = 1'b1;
      end
      chk(0, "t3_grants", glog.size(), 5);
      seq = 0;
      foreach (glog[k]) if (k < 5) seq = seq * 10 + glog[k];
      chk(0, "t3_order", seq, 12123);
      idle(8);
      // starvation count restarted: store wins again over a fresh fetch
      store_req[0] = 1'b1; fetch_req[0] = 1'b1;
      step(1'b0);
      chk(0, "t3_restart", store_ack[0], 1'b1);
      idle(10);

      // reset in the middle of BUSY, load pending
      load_req[0] = 1'b1;
      step(1'b0);
      step(1'b0);
      step(1'b0);
      chk(0, "t4_busy", busy[0], 1'b1);
      load_req[0] = 1'b1; reset = 1'b1;
      step(1'b0);
      chk(0, "t4_rst_busy", busy[0], 1'b0);
      chk(0, "t4_rst_cmd", p_cmd[0], BUS_NONE);
      chk(0, "t4_rst_ack", load_ack[0], 1'b0);
      reset = 1'b0;
      step(1'b0);
      chk(0, "t4_regrant", load_ack[0], 1'b1);
      idle(6);

      // LAT=0: back-to-back loads every other cycle
      pat = '0;
      for (int s = 0; s < 10; s++) begin
         if (!load_ack[1]) load_req[1] = 1'b1;
         step(1'b0);
         pat = {pat[8:0], load_ack[1]};
      end
      chk(1, "t5_pattern", pat, 10'h2AA);
      idle(3);

      for (int s = 0; s < 3000; s++) step(1'b1);
      reset = 1'b0;
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
